csa_pipelined_adder: RTL and testbench
======================================

// Module: csa_pipelined_adder
// PURPOSE
//  Parametrised, pipelined carry-select adder/subtractor with valid/ready flow control.
//  Generalises the fixed 16-bit/4-bit-block CSA: configurable width, block size and pipeline depth.
//  Adds a subtract mode, overflow and zero flags, and back-pressure.
//  Sits in the datapath as a streaming ALU arithmetic unit: one operation per cycle at full throughput.
// PARAMETERS
//  N       16  operand/sum width in bits; must be a multiple of K
//  K        4  carry-select block width; NB = N/K blocks
//  STAGES   2  pipeline register stages = latency; must divide NB; BPS = NB/STAGES blocks per stage
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  synchronous active-low reset
//  in_valid   in   1  operands A, B, C_in, sub are valid this cycle
//  in_ready   out  1  unit accepts the operands this cycle
//  A          in   N  operand A
//  B          in   N  operand B
//  C_in       in   1  carry-in; used only when sub=0
//  sub        in   1  1: S = A - B (~B, carry-in forced to 1); 0: S = A + B + C_in
//  out_valid  out  1  result fields are valid
//  out_ready  in   1  consumer takes the result this cycle
//  S          out  N  sum/difference
//  C_out      out  1  carry out of MSB; for sub, 1 means no borrow
//  V          out  1  signed overflow: carry into MSB XOR C_out
//  Z          out  1  S == 0
// BEHAVIOUR
//  - Reset (rst_n=0 at a clock edge):
//      - all stage valid bits, out_valid, S, C_out, V and Z go to 0.
//      - In-flight operations are discarded; in_ready reads 1 in the first cycle after reset.
//  - Handshake:
//      - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
//      - in_ready = !out_valid | out_ready (global advance).
//      - When advance=1, every stage register loads from its predecessor.
//      - Stage 0 loads in_valid (a bubble if in_valid=0).
//  - Stall (out_ready=0 while out_valid=1):
//      - All stages hold.
//      - S, C_out, V, Z stay stable until accepted.
//      - Inputs are not accepted.
//  - Latency: an accepted operand appears on out_valid exactly STAGES cycles later, absent stalls.
//    Throughput is 1 per cycle.
//  - Stage s (0..STAGES-1):
//      - Computes blocks s*BPS .. s*BPS+BPS-1.
//      - Uses the carry registered by stage s-1; stage 0 uses the effective carry-in.
//      - Each block computes sum/carry for carry-in 0 and 1 in parallel; the incoming carry
//        selects via mux, rippling the select across BPS blocks.
//      - Operand bits above the stage are skew-registered along with it.
//      - Sum bits already produced are deskew-registered so all N bits leave together.
//  - Width rules:
//      - Effective B = sub ? ~B : B; effective carry-in = sub ? 1 : C_in.
//      - S = (A + Beff + cin) mod 2^N.
//      - C_out = bit N of the N+1-bit result.
//      - V uses the carry into bit N-1, captured in the final stage.
//  - Wrap-around: 0xFFFF + 1 gives S=0, C_out=1, no error condition.
//  - Simultaneous input accept and output accept in the same cycle is legal; no bubble is inserted.
//  - Reset asserted together with in_valid: the operand is dropped.
// STRUCTURE
//  - Shared header csa_defs.vh:
//      - default N, K, STAGES.
//      - derived NB and BPS macros.
//      - compile-time checks: N%K==0 and NB%STAGES==0.
//  - Sub-module csa_select_block #(K) (combinational):
//      - inputs a, b, sel_c.
//      - outputs s, c_out, c_msb_in (carry into its MSB, used for V on the top block).
//      - Internally: two K-bit ripple adders plus sum/carry 2:1 muxes.
//  - Top level:
//      - generate loop over NB blocks.
//      - per-stage registers for valid, carry, skewed operands and deskewed sum bits.
// TESTING (N=16, K=4, STAGES=2)
//  1. add A=0xFFFF, B=0x0001, C_in=0 -> after 2 cycles S=0x0000, C_out=1, V=0, Z=1.
//  2. add A=0x7FFF, B=0x0001 -> S=0x8000, C_out=0, V=1, Z=0.
//     add A=0x1234, B=0x4321, C_in=1 -> S=0x5556.
//  3. sub A=0x8000, B=0x0001 -> S=0x7FFF, C_out=1, V=1.
//     sub A=0x0003, B=0x0005 -> S=0xFFFE, C_out=0, V=0.
//  4. Back-to-back operands 1..10 with out_ready=1 -> results in order, out_valid high 10
//     consecutive cycles starting at cycle 2.
//  5. Stream 5 ops; drop out_ready for 3 cycles after the first result.
//     -> in_ready=0 during the stall, S held stable, no loss or duplication, order preserved.
//  6. rst_n=0 for 1 cycle with 2 ops in flight -> out_valid=0, S=0 next cycle.
//     A new op issued after reset emerges 2 cycles later with the correct value.

Source files
------------

// File: rtl/csa_pipelined_adder_pkg.sv
// rtl/csa_pipelined_adder_pkg.sv - shared defaults, op encoding and geometry helpers for the CSA adder
// Purpose: default N/K/STAGES, the add/sub op encoding, and the functions that derive block
//          counts and the packing offsets of the per-stage pipeline registers.
// Ports:   none (package).
package csa_pipelined_adder_pkg;

  localparam int DEF_N      = 16;
  localparam int DEF_K      = 4;
  localparam int DEF_STAGES = 2;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int num_blocks(input int n, input int k);
    return n / k;
  endfunction

  function automatic int blocks_per_stage(input int n, input int k, input int stages);
    return (n / k) / stages;
  endfunction

  // Legal geometry: whole blocks, and whole blocks per stage.
  function automatic bit cfg_ok(input int n, input int k, input int stages);
    return (k > 0) && (stages > 0) && (n > 0) && ((n % k) == 0) && (((n / k) % stages) == 0);
  endfunction

  // Stage s holds (s+1)*w finished sum bits; stages are packed back to back.
  function automatic int sum_off(input int s, input int w);
    return (w * s * (s + 1)) / 2;
  endfunction

  // Stage s holds the n-(s+1)*w operand bits not yet added; packed back to back.
  function automatic int skew_off(input int s, input int n, input int w);
    return (s * n) - ((w * s * (s + 1)) / 2);
  endfunction

endpackage

// File: rtl/csa_pipelined_adder_if.sv
// rtl/csa_pipelined_adder_if.sv - valid/ready operand and result bundle for the CSA adder
// Purpose: groups the operand stream (in_*) and result stream (out_*) of the adder.
// Ports:   in_valid/in_ready, A, B, C_in, sub  - operand side (master drives, slave accepts)
//          out_valid/out_ready, S, C_out, V, Z - result side (slave drives, master consumes)
interface csa_pipelined_adder_if #(
  parameter int N = 16
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         C_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         C_out;
  logic         V;
  logic         Z;

  modport master (
    output in_valid, A, B, C_in, sub, out_ready,
    input  in_ready, out_valid, S, C_out, V, Z
  );

  modport slave (
    input  in_valid, A, B, C_in, sub, out_ready,
    output in_ready, out_valid, S, C_out, V, Z
  );

endinterface

// File: rtl/csa_pipelined_adder_select_block.sv
// rtl/csa_pipelined_adder_select_block.sv - one K-bit carry-select block (combinational)
// Purpose: adds a+b for carry-in 0 and 1 in parallel, then sel_c picks the matching result.
// Ports:   a, b      in  K  block operands
//          sel_c     in  1  actual carry into the block (mux select)
//          s         out K  selected sum
//          c_out     out 1  selected carry out of the block MSB
//          c_msb_in  out 1  selected carry into the block MSB (for signed overflow)
module csa_select_block #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         sel_c,
  output logic [K-1:0] s,
  output logic         c_out,
  output logic         c_msb_in
);

  logic [K:0]   c0;
  logic [K:0]   c1;
  logic [K-1:0] s0;
  logic [K-1:0] s1;

  // Two independent ripple adders, one assuming carry-in 0, one assuming 1.
  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < K; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  assign s        = sel_c ? s1 : s0;
  assign c_out    = sel_c ? c1[K] : c0[K];
  assign c_msb_in = sel_c ? c1[K-1] : c0[K-1];

endmodule

// File: rtl/csa_pipelined_adder.sv
// rtl/csa_pipelined_adder.sv - pipelined carry-select adder/subtractor with valid/ready flow control
// Purpose: S = A + (sub ? ~B : B) + (sub ? 1 : C_in), split over STAGES register stages of
//          BPS carry-select blocks each; one operation per cycle, latency STAGES.
// Ports:   clk    in  1  rising-edge clock
//          rst_n  in  1  synchronous active-low reset
//          bus    slave modport of csa_pipelined_adder_if (operand and result streams)
module csa_pipelined_adder
  import csa_pipelined_adder_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int K      = DEF_K,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  csa_pipelined_adder_if.slave  bus
);

  localparam int NB       = num_blocks(N, K);
  localparam int BPS      = blocks_per_stage(N, K, STAGES);
  localparam int W        = BPS * K;
  localparam int SUM_W    = sum_off(STAGES, W);
  localparam int SKEW_RAW = skew_off(STAGES - 1, N, W);
  localparam int SKEW_W   = (SKEW_RAW > 0) ? SKEW_RAW : 1;

  if (!cfg_ok(N, K, STAGES)) begin : g_cfg_check
    $error("csa_pipelined_adder: N must be a multiple of K and N/K a multiple of STAGES");
  end

  op_e               op;
  logic [N-1:0]      b_eff;
  logic              cin_eff;
  logic              advance;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cry_q;
  logic [SUM_W-1:0]  sum_q;
  logic [SKEW_W-1:0] skew_a_q;
  logic [SKEW_W-1:0] skew_b_q;
  logic              v_q;
  logic              z_q;

  logic [N-1:0]      blk_s;
  logic [NB-1:0]     blk_cmsb;
  logic              unused_cmsb;

  assign op      = op_e'(bus.sub);
  assign b_eff   = (op == OP_SUB) ? ~bus.B : bus.B;
  assign cin_eff = (op == OP_SUB) ? 1'b1 : bus.C_in;

  // Single global advance: the whole pipe moves or the whole pipe holds.
  assign advance      = !vld_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;

  // Only the top block's carry-into-MSB feeds V; the rest are by-products.
  assign unused_cmsb = ^blk_cmsb;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO   = s * W;
    localparam int UP_W = N - LO;

    logic [UP_W-1:0]   up_a;
    logic [UP_W-1:0]   up_b;
    logic              c_src;
    logic              v_src;
    logic [LO+W-1:0]   stage_sum;

    // Stage inputs: raw operands for stage 0, skewed registers of the previous stage otherwise.
    if (s == 0) begin : g_first
      assign up_a      = bus.A;
      assign up_b      = b_eff;
      assign c_src     = cin_eff;
      assign v_src     = bus.in_valid;
      assign stage_sum = blk_s[W-1:0];
    end else begin : g_next
      localparam int SK_PREV  = skew_off(s - 1, N, W);
      localparam int SUM_PREV = sum_off(s - 1, W);
      assign up_a      = skew_a_q[SK_PREV +: UP_W];
      assign up_b      = skew_b_q[SK_PREV +: UP_W];
      assign c_src     = cry_q[s-1];
      assign v_src     = vld_q[s-1];
      assign stage_sum = {blk_s[LO +: W], sum_q[SUM_PREV +: LO]};
    end

    // Blocks of this stage; the select carry ripples from block to block through scalars
    // so the chain does not form a combinational loop on a single vector.
    for (genvar j = 0; j < BPS; j++) begin : g_blk
      localparam int G = s * BPS + j;

      logic sel_c;
      logic c_o;

      if (j == 0) begin : g_head
        assign sel_c = c_src;
      end else begin : g_tail
        assign sel_c = g_blk[j-1].c_o;
      end

      csa_select_block #(
        .K(K)
      ) u_blk (
        .a        (up_a[j*K +: K]),
        .b        (up_b[j*K +: K]),
        .sel_c    (sel_c),
        .s        (blk_s[G*K +: K]),
        .c_out    (c_o),
        .c_msb_in (blk_cmsb[G])
      );
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q[s]                    <= 1'b0;
        cry_q[s]                    <= 1'b0;
        sum_q[sum_off(s, W) +: LO+W] <= '0;
      end else if (advance) begin
        vld_q[s]                    <= v_src;
        cry_q[s]                    <= g_blk[BPS-1].c_o;
        sum_q[sum_off(s, W) +: LO+W] <= stage_sum;
      end
    end

    if (s < STAGES - 1) begin : g_skew
      localparam int SK = skew_off(s, N, W);
      localparam int NW = UP_W - W;

      // Operand bits still to be added travel alongside the partial sum.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          skew_a_q[SK +: NW] <= '0;
          skew_b_q[SK +: NW] <= '0;
        end else if (advance) begin
          skew_a_q[SK +: NW] <= up_a[UP_W-1:W];
          skew_b_q[SK +: NW] <= up_b[UP_W-1:W];
        end
      end
    end else begin : g_last
      // Flags are registered with the final stage so they line up with S.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= 1'b0;
          z_q <= 1'b0;
        end else if (advance) begin
          v_q <= blk_cmsb[NB-1] ^ g_blk[BPS-1].c_o;
          z_q <= (stage_sum == '0);
        end
      end
    end
  end

  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.S         = sum_q[sum_off(STAGES - 1, W) +: N];
  assign bus.C_out     = cry_q[STAGES-1];
  assign bus.V         = v_q;
  assign bus.Z         = z_q;

endmodule

// File: tb/tb_csa_pipelined_adder.sv
// tb/tb_csa_pipelined_adder.sv - self-checking bench for csa_pipelined_adder (N=16, K=4, STAGES=2)
module tb_csa_pipelined_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  csa_pipelined_adder_if #(.N(16)) bus_if ();

  csa_pipelined_adder #(
    .N      (16),
    .K      (4),
    .STAGES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t        vecs [13];
  logic [15:0] ops_a   [16];
  logic [15:0] ops_b   [16];
  logic        ops_cin [16];
  logic        ops_sub [16];
  int          lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result {Z, V, C_out, S} from plain 17-bit arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    logic [15:0] be;
    logic        ci;
    logic [16:0] full;
    logic [15:0] lo;
    be   = sub ? ~b : b;
    ci   = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, be} + {16'b0, ci};
    lo   = {1'b0, a[14:0]} + {1'b0, be[14:0]} + {15'b0, ci};
    return {(full[15:0] == 16'h0000), lo[15] ^ full[16], full[16], full[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus_if.in_valid = 1'b0;
    bus_if.A        = 16'h0000;
    bus_if.B        = 16'h0000;
    bus_if.C_in     = 1'b0;
    bus_if.sub      = 1'b0;
  endtask

  task automatic run_stream(input int n, input int stall_len, input bit check_timing);
    logic [18:0] exp_q [$];
    logic [18:0] e;
    logic [15:0] held_s;
    int          k, sent, got, first_out, idx;
    bit          in_stall, prev_stall;
    k = 0; sent = 0; got = 0; first_out = -1; prev_stall = 0; held_s = 16'h0;
    while (got < n && k < 100) begin
      idx             = (sent < n) ? sent : 0;
      in_stall        = (first_out >= 0) && (k > first_out) && (k <= first_out + stall_len);
      bus_if.in_valid = (sent < n);
      bus_if.A        = ops_a[idx];
      bus_if.B        = ops_b[idx];
      bus_if.C_in     = ops_cin[idx];
      bus_if.sub      = ops_sub[idx];
      bus_if.out_ready = !in_stall;
      #1;
      if (in_stall) begin
        chk("stall_out_valid", 32'(bus_if.out_valid), 32'd1);
        chk("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
      end
      if (prev_stall) chk("stall_S_held", 32'(bus_if.S), 32'(held_s));
      if (bus_if.in_valid && bus_if.in_ready) begin
        exp_q.push_back(model(ops_a[idx], ops_b[idx], ops_cin[idx], ops_sub[idx]));
        sent++;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
        chk($sformatf("stream%0d_res%0d", n, got),
            32'({bus_if.Z, bus_if.V, bus_if.C_out, bus_if.S}), 32'(e));
        if (check_timing) chk($sformatf("stream_cycle%0d", got), 32'(k), 32'(got + 2));
        if (first_out < 0) first_out = k;
        got++;
      end
      held_s     = bus_if.S;
      prev_stall = in_stall;
      tick();
      k++;
    end
    drive_idle();
    bus_if.out_ready = 1'b1;
    chk("stream_sent", 32'(sent), 32'(n));
    chk("stream_got", 32'(got), 32'(n));
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
    #1;
    chk("stream_drained", 32'(bus_if.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              a         b         cin   sub   s         c     v     z
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h00FF, 16'hFF00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0, 1'b0};

    // Reset state; out_ready low so in_ready can only come from !out_valid.
    rst_n            = 1'b0;
    drive_idle();
    bus_if.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_S", 32'(bus_if.S), 32'd0);
    chk("rst_flags", 32'({bus_if.C_out, bus_if.V, bus_if.Z}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    bus_if.out_ready = 1'b1;

    // Single operations: latency and every result field.
    for (int i = 0; i < 13; i++) begin
      bus_if.A        = vecs[i].a;
      bus_if.B        = vecs[i].b;
      bus_if.C_in     = vecs[i].cin;
      bus_if.sub      = vecs[i].sub;
      bus_if.in_valid = 1'b1;
      tick();
      drive_idle();
      lat = 1;
      while (!bus_if.out_valid && lat < 8) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_S", i), 32'(bus_if.S), 32'(vecs[i].s));
      chk($sformatf("vec%0d_C_out", i), 32'(bus_if.C_out), 32'(vecs[i].c));
      chk($sformatf("vec%0d_V", i), 32'(bus_if.V), 32'(vecs[i].v));
      chk($sformatf("vec%0d_Z", i), 32'(bus_if.Z), 32'(vecs[i].z));
      tick();
    end

    // Back-to-back operands 1..10, full throughput from cycle 2.
    for (int i = 0; i < 10; i++) begin
      ops_a[i]   = 16'(i + 1);
      ops_b[i]   = 16'((i + 1) << 8);
      ops_cin[i] = 1'b0;
      ops_sub[i] = 1'b0;
    end
    run_stream(10, 0, 1'b1);

    // Five mixed operations with a 3-cycle consumer stall after the first result.
    ops_a[0] = 16'h7FFF; ops_b[0] = 16'h0001; ops_cin[0] = 1'b0; ops_sub[0] = 1'b0;
    ops_a[1] = 16'h0001; ops_b[1] = 16'h0002; ops_cin[1] = 1'b0; ops_sub[1] = 1'b1;
    ops_a[2] = 16'hABCD; ops_b[2] = 16'h1111; ops_cin[2] = 1'b0; ops_sub[2] = 1'b1;
    ops_a[3] = 16'h8000; ops_b[3] = 16'h8000; ops_cin[3] = 1'b1; ops_sub[3] = 1'b0;
    ops_a[4] = 16'h00FF; ops_b[4] = 16'h0001; ops_cin[4] = 1'b0; ops_sub[4] = 1'b0;
    run_stream(5, 3, 1'b0);

    // Reset with two operations in flight and a third offered during reset.
    bus_if.A = 16'h1111; bus_if.B = 16'h2222; bus_if.in_valid = 1'b1;
    tick();
    bus_if.A = 16'h3333; bus_if.B = 16'h4444;
    tick();
    chk("inflight_out_valid", 32'(bus_if.out_valid), 32'd1);
    rst_n    = 1'b0;
    bus_if.A = 16'h5555; bus_if.B = 16'h0001;
    tick();
    chk("rst2_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst2_S", 32'(bus_if.S), 32'd0);
    rst_n    = 1'b1;
    bus_if.A = 16'h0ABC; bus_if.B = 16'h0101;
    #1;
    chk("rst2_in_ready", 32'(bus_if.in_ready), 32'd1);
    tick();
    drive_idle();
    chk("post_rst_bubble", 32'(bus_if.out_valid), 32'd0);
    tick();
    chk("post_rst_valid", 32'(bus_if.out_valid), 32'd1);
    chk("post_rst_S", 32'(bus_if.S), 32'h0BBD);
    chk("post_rst_flags", 32'({bus_if.C_out, bus_if.V, bus_if.Z}), 32'd0);
    tick();
    chk("post_rst_drain", 32'(bus_if.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
